// File: rtl/bitcoin_sha256_pkg.sv
// bitcoin_sha256_pkg
// Shared types and constants for the nonce scheduler and the simplified
// SHA-256 core that sits beside it at the parent level.
package bitcoin_sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int MSG_WORDS      = 16;
  localparam int HASH_WORDS     = 8;
  localparam int NONCE_WORD_IDX = 3;

  // Worst possible first digest word; any real result at or below it competes.
  localparam word_t H0_WORST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_e;

  // Strict comparison so that an equal digest keeps the earlier nonce.
  function automatic logic h0_improves(input word_t cand, input word_t best);
    return (cand < best);
  endfunction

endpackage

// File: rtl/bitcoin_nonce_scheduler.sv
// bitcoin_nonce_scheduler
// Sweeps nonces 0..NUM_NONCES-1 through an external simplified SHA-256 core.
// For each nonce it presents the latched header (nonce in word 3) and the
// latched midstate, waits for the core, and streams {nonce, h0} out over a
// valid/ready handshake. A one-cycle done pulse closes the job.
// The core's reset_n must be tied to ~reset at the parent so both abort together.
// Optional feature: define NONCE_SCHED_MIN_TRACK_EN to add the best_h0 /
// best_nonce outputs, which track the smallest h0 seen in the job.
module bitcoin_nonce_scheduler
  import bitcoin_sha256_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] header_msg [MSG_WORDS],
  input  logic [31:0] midstate [HASH_WORDS],
  output logic        core_start,
  output logic [31:0] core_message [MSG_WORDS],
  output logic [31:0] core_starter_hash [HASH_WORDS],
  input  logic        core_done,
  input  logic [31:0] core_hash [HASH_WORDS],
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_nonce,
  output logic [31:0] res_h0,
  output logic        busy,
`ifdef NONCE_SCHED_MIN_TRACK_EN
  output logic [31:0] best_h0,
  output logic [31:0] best_nonce,
`endif
  output logic        done
);

  localparam word_t LAST_NONCE = word_t'(NUM_NONCES - 1);

  sched_state_e state_q, state_d;
  word_t        nonce_q, nonce_d;
  word_t        hdr_q [MSG_WORDS];
  word_t        hdr_d [MSG_WORDS];
  word_t        mid_q [HASH_WORDS];
  word_t        mid_d [HASH_WORDS];
  logic         core_start_q, core_start_d;
  logic         res_valid_q, res_valid_d;
  word_t        res_nonce_q, res_nonce_d;
  word_t        res_h0_q, res_h0_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef NONCE_SCHED_MIN_TRACK_EN
  word_t        best_h0_q, best_h0_d;
  word_t        best_nonce_q, best_nonce_d;
`endif

  // The nonce slot of the latched header and digest words 1..7 are never used.
  logic unused_bits_s;

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    hdr_d        = hdr_q;
    mid_d        = mid_q;
    core_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_nonce_d  = res_nonce_q;
    res_h0_d     = res_h0_q;
    done_d       = 1'b0;
`ifdef NONCE_SCHED_MIN_TRACK_EN
    best_h0_d    = best_h0_q;
    best_nonce_d = best_nonce_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Header and midstate are frozen here for the whole job.
          hdr_d   = header_msg;
          mid_d   = midstate;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        nonce_d      = 32'd0;
        core_start_d = 1'b1;
        state_d      = ST_ISSUE;
`ifdef NONCE_SCHED_MIN_TRACK_EN
        best_h0_d    = H0_WORST;
        best_nonce_d = 32'd0;
`endif
      end

      ST_ISSUE: begin
        // core_start was raised on entry; it drops as we leave.
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done) begin
          res_h0_d    = core_hash[0];
          res_nonce_d = nonce_q;
          res_valid_d = 1'b1;
          state_d     = ST_EMIT;
`ifdef NONCE_SCHED_MIN_TRACK_EN
          if (h0_improves(core_hash[0], best_h0_q)) begin
            best_h0_d    = core_hash[0];
            best_nonce_d = nonce_q;
          end else begin
            best_h0_d    = best_h0_q;
            best_nonce_d = best_nonce_q;
          end
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (nonce_q == LAST_NONCE) begin
            // Last nonce consumed: the counter stops here and never wraps.
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            nonce_d      = nonce_q + 32'd1;
            core_start_d = 1'b1;
            state_d      = ST_ISSUE;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any job and clears the latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      nonce_q      <= 32'd0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_nonce_q  <= 32'd0;
      res_h0_q     <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        hdr_q[i] <= 32'd0;
      end
      for (int i = 0; i < HASH_WORDS; i++) begin
        mid_q[i] <= 32'd0;
      end
`ifdef NONCE_SCHED_MIN_TRACK_EN
      best_h0_q    <= H0_WORST;
      best_nonce_q <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      nonce_q      <= nonce_d;
      core_start_q <= core_start_d;
      res_valid_q  <= res_valid_d;
      res_nonce_q  <= res_nonce_d;
      res_h0_q     <= res_h0_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hdr_q        <= hdr_d;
      mid_q        <= mid_d;
`ifdef NONCE_SCHED_MIN_TRACK_EN
      best_h0_q    <= best_h0_d;
      best_nonce_q <= best_nonce_d;
`endif
    end
  end

  // Core message: latched header with the live nonce substituted into its slot.
  always_comb begin
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (i == NONCE_WORD_IDX) begin
        core_message[i] = nonce_q;
      end else begin
        core_message[i] = hdr_q[i];
      end
    end
  end

  // Fold of the deliberately ignored bits.
  always_comb begin
    unused_bits_s = ^hdr_q[NONCE_WORD_IDX];
    for (int i = 1; i < HASH_WORDS; i++) begin
      unused_bits_s = unused_bits_s ^ (^core_hash[i]);
    end
  end

  assign core_starter_hash = mid_q;
  assign core_start        = core_start_q;
  assign res_valid         = res_valid_q;
  assign res_nonce         = res_nonce_q;
  assign res_h0            = res_h0_q;
  assign busy              = busy_q;
  assign done              = done_q;
`ifdef NONCE_SCHED_MIN_TRACK_EN
  assign best_h0           = best_h0_q;
  assign best_nonce        = best_nonce_q;
`endif

endmodule

// File: tb/tb_bitcoin_nonce_scheduler.sv
// tb_bitcoin_nonce_scheduler
// Table of jobs (header/midstate bases, per-nonce h0 values, ready stall,
// expected best) applied in a loop, plus hand sequences for EMIT stalls,
// spurious core_done, and reset in the middle of a job. A fixed-latency
// core model answers each core_start with the table h0 for that nonce.
module tb_bitcoin_nonce_scheduler;

  localparam int N      = 4;
  localparam int LAT    = 70;
  localparam int BUDGET = 3000;
  localparam int NJOBS  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] header_msg [16];
  logic [31:0] midstate [8];
  logic        core_start;
  logic [31:0] core_message [16];
  logic [31:0] core_starter_hash [8];
  logic        core_done;
  logic [31:0] core_hash [8];
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  logic [31:0] res_h0;
  logic        busy;
  logic        done;
`ifdef NONCE_SCHED_MIN_TRACK_EN
  logic [31:0] best_h0;
  logic [31:0] best_nonce;
  logic [31:0] exp_best_h0;
  logic [31:0] exp_best_nonce;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state for the current job.
  logic [31:0] h0_tab [N];
  logic [31:0] exp_hdr [16];
  logic [31:0] exp_mid [8];
  int          exp_issue;
  int          exp_res;
  int          n_start;
  int          n_res;
  int          n_done;
  logic        hold_pending;
  logic [31:0] hold_nonce;
  logic [31:0] hold_h0;

  // Core model and spurious-pulse injector.
  int          rem;
  logic        model_done;
  logic [31:0] model_h0;
  logic [31:0] pending_h0;
  logic [31:0] model_other [8];
  logic        spur_done;
  logic [31:0] spur_h0;

  typedef struct packed {
    logic [31:0]       hbase;
    logic [31:0]       mbase;
    logic [31:0]       stall;
    logic              disturb;
    logic [3:0][31:0]  h0;
    logic [31:0]       best_h0;
    logic [31:0]       best_nonce;
  } job_t;

  job_t jobs [NJOBS];

  bitcoin_nonce_scheduler #(.NUM_NONCES(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .header_msg        (header_msg),
    .midstate          (midstate),
    .core_start        (core_start),
    .core_message      (core_message),
    .core_starter_hash (core_starter_hash),
    .core_done         (core_done),
    .core_hash         (core_hash),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_nonce         (res_nonce),
    .res_h0            (res_h0),
    .busy              (busy),
`ifdef NONCE_SCHED_MIN_TRACK_EN
    .best_h0           (best_h0),
    .best_nonce        (best_nonce),
`endif
    .done              (done)
  );

  always #5 clk = ~clk;

  assign core_done = model_done | spur_done;

  // Digest bus: model result when it completes, otherwise the injected junk.
  always_comb begin
    core_hash[0] = model_done ? model_h0 : spur_h0;
    for (int i = 1; i < 8; i++) core_hash[i] = model_other[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic job_t mk_job(input logic [31:0] hbase, input logic [31:0] mbase,
                                  input int stall, input logic disturb,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d,
                                  input logic [31:0] bh, input logic [31:0] bn);
    job_t j;
    j.hbase = hbase; j.mbase = mbase; j.stall = 32'(stall); j.disturb = disturb;
    j.h0[0] = a; j.h0[1] = b; j.h0[2] = c; j.h0[3] = d;
    j.best_h0 = bh; j.best_nonce = bn;
    return j;
  endfunction

  // Smallest h0 over the job; first occurrence wins on ties.
  function automatic job_t with_model_best(input job_t j);
    job_t o = j;
    o.best_h0    = 32'hFFFF_FFFF;
    o.best_nonce = 32'd0;
    for (int k = 0; k < N; k++) begin
      if (j.h0[k] < o.best_h0) begin
        o.best_h0    = j.h0[k];
        o.best_nonce = 32'(k);
      end
    end
    return o;
  endfunction

  // Core model: answers each core_start LAT cycles later with the table h0 for its nonce.
  initial begin
    rem = 0; model_done = 1'b0; model_h0 = 32'd0; pending_h0 = 32'd0;
    for (int i = 0; i < 8; i++) model_other[i] = 32'd0;
    forever begin
      @(posedge clk); #2;
      model_done = 1'b0;
      if (reset) begin
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            model_done = 1'b1;
            model_h0   = pending_h0;
            for (int i = 1; i < 8; i++) model_other[i] = $urandom;
          end
        end
        if (core_start) begin
          rem        = LAT;
          pending_h0 = (core_message[3] < 32'(N)) ? h0_tab[core_message[3][1:0]] : 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset == 1'b0) begin
      if (core_start) begin
        for (int i = 0; i < 16; i++)
          chk("core_message", core_message[i], (i == 3) ? 32'(exp_issue) : exp_hdr[i]);
        for (int i = 0; i < 8; i++)
          chk("core_starter_hash", core_starter_hash[i], exp_mid[i]);
        exp_issue++;
        n_start++;
      end
      if (hold_pending) begin
        chk("emit_hold_valid", 32'(res_valid), 32'd1);
        chk("emit_hold_nonce", res_nonce, hold_nonce);
        chk("emit_hold_h0", res_h0, hold_h0);
      end
      if (res_valid) chk("no_start_in_emit", 32'(core_start), 32'd0);
      if (res_valid && res_ready) begin
        chk("res_nonce", res_nonce, 32'(exp_res));
        chk("res_h0", res_h0, (exp_res < N) ? h0_tab[exp_res[1:0]] : 32'hBAD0_BAD0);
        exp_res++;
        n_res++;
      end
      hold_pending = res_valid && !res_ready;
      hold_nonce   = res_nonce;
      hold_h0      = res_h0;
      if (done) begin
        n_done++;
`ifdef NONCE_SCHED_MIN_TRACK_EN
        chk("best_h0", best_h0, exp_best_h0);
        chk("best_nonce", best_nonce, exp_best_nonce);
`endif
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_res_nonce"}, res_nonce, 32'd0);
    chk({tag, "_res_h0"}, res_h0, 32'd0);
    for (int i = 0; i < 16; i++) chk({tag, "_core_message"}, core_message[i], 32'd0);
    for (int i = 0; i < 8; i++) chk({tag, "_core_starter_hash"}, core_starter_hash[i], 32'd0);
`ifdef NONCE_SCHED_MIN_TRACK_EN
    chk({tag, "_best_h0"}, best_h0, 32'hFFFF_FFFF);
    chk({tag, "_best_nonce"}, best_nonce, 32'd0);
`endif
  endtask

  // Called #1 after a posedge with the DUT idle; returns in the first ISSUE cycle.
  task automatic start_job(input job_t j);
    for (int k = 0; k < N; k++) h0_tab[k] = j.h0[k];
    for (int i = 0; i < 16; i++) begin
      header_msg[i] = j.hbase + 32'(i);
      exp_hdr[i]    = j.hbase + 32'(i);
    end
    for (int i = 0; i < 8; i++) begin
      midstate[i] = j.mbase + 32'(i);
      exp_mid[i]  = j.mbase + 32'(i);
    end
`ifdef NONCE_SCHED_MIN_TRACK_EN
    exp_best_h0    = j.best_h0;
    exp_best_nonce = j.best_nonce;
`endif
    exp_issue = 0; exp_res = 0; n_start = 0; n_res = 0; n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("core_start_in_load", 32'(core_start), 32'd0);
    @(posedge clk); #1;
    chk("core_start_two_after", 32'(core_start), 32'd1);
  endtask

  task automatic wait_job(input int stall, input logic disturb);
    int cyc = 0;
    while (n_done == 0 && cyc < BUDGET) begin
      res_ready = (stall == 0) ? 1'b1 : ($urandom_range(stall, 0) == 0);
      if (disturb && cyc == 20) begin
        start = 1'b1;
        for (int i = 0; i < 16; i++) header_msg[i] = 32'hDEAD_0000 + 32'(i);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    res_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("job_done_pulses", 32'(n_done), 32'd1);
    chk("job_starts", 32'(n_start), 32'(N));
    chk("job_results", 32'(n_res), 32'(N));
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; res_ready = 1'b0; spur_done = 1'b0; spur_h0 = 32'd0;
    hold_pending = 1'b0; hold_nonce = 32'd0; hold_h0 = 32'd0;
    exp_issue = 0; exp_res = 0; n_start = 0; n_res = 0; n_done = 0;
    for (int i = 0; i < 16; i++) begin header_msg[i] = 32'd0; exp_hdr[i] = 32'd0; end
    for (int i = 0; i < 8; i++) begin midstate[i] = 32'd0; exp_mid[i] = 32'd0; end
    for (int k = 0; k < N; k++) h0_tab[k] = 32'd0;
`ifdef NONCE_SCHED_MIN_TRACK_EN
    exp_best_h0 = 32'hFFFF_FFFF; exp_best_nonce = 32'd0;
`endif

    jobs[0] = mk_job(32'h1000, 32'hA000, 0, 1'b0, 32'h30, 32'h10, 32'h10, 32'h20, 32'h10, 32'd1);
    jobs[1] = mk_job(32'h2000, 32'hB000, 3, 1'b1, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'd0);
    jobs[2] = mk_job(32'h3000, 32'hC000, 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFE, 32'h0, 32'h0, 32'd3);
    jobs[3] = mk_job(32'h4000, 32'hD000, 2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    for (int r = 4; r < NJOBS; r++) begin
      logic [31:0] v [4];
      for (int k = 0; k < 4; k++) v[k] = (r % 2 == 1) ? 32'($urandom_range(3, 0)) : $urandom;
      jobs[r] = with_model_best(mk_job(32'h5000 + 32'(r * 256), 32'h9000 + 32'(r * 256),
                                       int'($urandom_range(3, 0)), (r == 5),
                                       v[0], v[1], v[2], v[3], 32'd0, 32'd0));
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < NJOBS; t++) begin
      start_job(jobs[t]);
      wait_job(int'(jobs[t].stall), jobs[t].disturb);
    end

    // EMIT held off for 10 cycles with a spurious core_done, then one in ISSUE.
    start_job(jobs[0]);
    res_ready = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("emit_reached", 32'(res_valid), 32'd1);
    spur_h0 = 32'hDEAD_BEEF; spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("emit_still_valid", 32'(res_valid), 32'd1);
    chk("emit_first_nonce", res_nonce, 32'd0);
    chk("emit_first_h0", res_h0, 32'h30);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("issue_after_handshake", 32'(core_start), 32'd1);
    res_ready = 1'b0;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    wait_job(0, 1'b0);

    // Reset while waiting on nonce 2, then a fresh job restarting at nonce 0.
    start_job(jobs[2]);
    cyc = 0;
    while (n_start < 3 && cyc < 1000) begin res_ready = 1'b1; @(posedge clk); #1; cyc++; end
    chk("third_issue_seen", 32'(n_start), 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("reset_mid");
    repeat (100) begin @(posedge clk); #1; end
    chk("abandoned_results", 32'(n_res), 32'd2);
    chk("abandoned_done", 32'(n_done), 32'd0);
    chk("abandoned_busy", 32'(busy), 32'd0);
    start_job(jobs[0]);
    wait_job(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
